// File: rtl/mini_alu_gen2_if.sv
// Bus bundle between mini_alu_gen2 and its instruction ROM / board I/O.
// master = the ALU core, slave = the environment feeding instructions.
interface mini_alu_gen2_if #(
   parameter int ADDR_W = 8
);
   logic [4+3*ADDR_W-1:0] iInstruction;
   logic [ADDR_W-1:0]     oInstrAddr;
   logic [7:0]            oLed;
   logic                  oBusy;

   modport master (input iInstruction, output oInstrAddr, oLed, oBusy);
   modport slave  (output iInstruction, input oInstrAddr, oLed, oBusy);
endinterface

// File: rtl/mini_alu_gen2.sv
// Two-stage (fetch/execute) mini ALU with register file, branches and LED output.
// Optional shift-add IMUL unit compiled in when MINI_ALU_GEN2_MUL_EN is defined.
module mini_alu_gen2 #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 8,
   parameter int RF_DEPTH = 256
) (
   input logic             Clock,
   input logic             Reset,
   mini_alu_gen2_if.master bus
);
   localparam int IW = 4 + 3*ADDR_W;

   localparam logic [3:0] OP_LED = 4'd1;
   localparam logic [3:0] OP_BLE = 4'd2;
   localparam logic [3:0] OP_STO = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4;
   localparam logic [3:0] OP_JMP = 4'd5;
   localparam logic [3:0] OP_SUB = 4'd6;

   logic [IW-1:0]     r_ir;
   logic [ADDR_W-1:0] r_pc;
   logic [7:0]        r_led;
   logic [DATA_W-1:0] r_rf [RF_DEPTH];

   logic [3:0]        w_op;
   logic [ADDR_W-1:0] w_dst, w_src1, w_src0;
   logic [DATA_W-1:0] w_rd1, w_rd0;
   logic              w_idle, w_hold, w_branch, w_led_ld;
   logic              w_we, w_we_hi;
   logic [ADDR_W-1:0] w_wa, w_wa_hi;
   logic [DATA_W-1:0] w_wdata, w_wdata_hi;

   function automatic logic f_in_rf(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < (ADDR_W+1)'(RF_DEPTH));
   endfunction

   function automatic logic [DATA_W-1:0] f_imm(input logic [ADDR_W-1:0] hi, input logic [ADDR_W-1:0] lo);
      logic [2*ADDR_W+DATA_W-1:0] t;
      t = {{DATA_W{1'b0}}, hi, lo};
      return t[DATA_W-1:0];
   endfunction

   assign w_op   = r_ir[IW-1 -: 4];
   assign w_dst  = r_ir[3*ADDR_W-1 -: ADDR_W];
   assign w_src1 = r_ir[2*ADDR_W-1 -: ADDR_W];
   assign w_src0 = r_ir[ADDR_W-1:0];
   assign w_rd1  = f_in_rf(w_src1) ? r_rf[w_src1] : '0;
   assign w_rd0  = f_in_rf(w_src0) ? r_rf[w_src0] : '0;

`ifdef MINI_ALU_GEN2_MUL_EN
   localparam int         CW      = $clog2(DATA_W);
   localparam logic [3:0] OP_IMUL = 4'd7;

   typedef enum logic {S_IDLE, S_MUL} state_e;

   state_e              r_state;
   logic [CW-1:0]       r_cnt;
   logic                r_busy;
   logic [2*DATA_W-1:0] r_ma, r_acc;
   logic [DATA_W-1:0]   r_mb;
   logic [ADDR_W-1:0]   r_mdst;
   logic [2*DATA_W-1:0] w_acc_nxt;
   logic [ADDR_W:0]     w_hi_sum;
   logic                w_mul_start, w_mul_last;

   assign w_idle     = (r_state == S_IDLE);
   assign w_mul_last = (r_state == S_MUL) && (r_cnt == CW'(DATA_W-1));
   assign w_hold     = w_mul_start || ((r_state == S_MUL) && !w_mul_last);
   assign w_acc_nxt  = r_acc + (r_mb[0] ? r_ma : '0);
   assign w_hi_sum   = {1'b0, r_mdst} + 1'b1;
   assign w_wa_hi    = (w_hi_sum >= (ADDR_W+1)'(RF_DEPTH)) ? '0 : w_hi_sum[ADDR_W-1:0];
   assign bus.oBusy  = r_busy;
`else
   assign w_idle     = 1'b1;
   assign w_hold     = 1'b0;
   assign w_wa_hi    = '0;
   assign bus.oBusy  = 1'b0;
`endif

   // Execute: decode IR; the final multiply cycle owns both write ports
   always_comb begin
      w_we       = 1'b0;
      w_wa       = w_dst;
      w_wdata    = '0;
      w_we_hi    = 1'b0;
      w_wdata_hi = '0;
      w_branch   = 1'b0;
      w_led_ld   = 1'b0;
`ifdef MINI_ALU_GEN2_MUL_EN
      w_mul_start = 1'b0;
      if (w_mul_last) begin
         w_we       = 1'b1;
         w_wa       = r_mdst;
         w_wdata    = w_acc_nxt[DATA_W-1:0];
         w_we_hi    = 1'b1;
         w_wdata_hi = w_acc_nxt[2*DATA_W-1:DATA_W];
      end else
`endif
      if (w_idle) begin
         case (w_op)
            OP_LED: w_led_ld = 1'b1;
            OP_BLE: w_branch = (w_rd1 <= w_rd0);
            OP_STO: begin w_we = 1'b1; w_wdata = f_imm(w_src1, w_src0); end
            OP_ADD: begin w_we = 1'b1; w_wdata = w_rd1 + w_rd0; end
            OP_JMP: w_branch = 1'b1;
            OP_SUB: begin w_we = 1'b1; w_wdata = w_rd1 - w_rd0; end
`ifdef MINI_ALU_GEN2_MUL_EN
            OP_IMUL: w_mul_start = 1'b1;
`endif
            default: ;
         endcase
      end
   end

   // Fetch / control state; a taken branch squashes the fetched word into a NOP
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_pc  <= '0;
         r_ir  <= '0;
         r_led <= '0;
`ifdef MINI_ALU_GEN2_MUL_EN
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
`endif
      end else begin
         if (w_led_ld) r_led <= w_rd1[7:0];
`ifdef MINI_ALU_GEN2_MUL_EN
         case (r_state)
            S_IDLE: if (w_mul_start) begin
               r_state <= S_MUL;
               r_busy  <= 1'b1;
               r_cnt   <= '0;
            end
            S_MUL: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_mul_last) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
`endif
         if (w_branch) begin
            r_pc <= w_dst;
            r_ir <= '0;
         end else if (!w_hold) begin
            r_ir <= bus.iInstruction;
            r_pc <= r_pc + 1'b1;
         end
      end
   end

`ifdef MINI_ALU_GEN2_MUL_EN
   // Multiplier datapath: operands frozen at entry so dst may alias a source
   always_ff @(posedge Clock) begin
      if (w_mul_start) begin
         r_ma   <= {{DATA_W{1'b0}}, w_rd1};
         r_mb   <= w_rd0;
         r_acc  <= '0;
         r_mdst <= w_dst;
      end else if (r_state == S_MUL) begin
         r_acc <= w_acc_nxt;
         r_ma  <= r_ma << 1;
         r_mb  <= r_mb >> 1;
      end
   end
`endif

   always_ff @(posedge Clock) begin
      if (w_we && f_in_rf(w_wa))       r_rf[w_wa]    <= w_wdata;
      if (w_we_hi && f_in_rf(w_wa_hi)) r_rf[w_wa_hi] <= w_wdata_hi;
   end

   assign bus.oInstrAddr = r_pc;
   assign bus.oLed       = r_led;
endmodule

// File: tb/tb_mini_alu_gen2.sv
// Directed bench for mini_alu_gen2: a ROM array feeds instructions, checks via
// immediate assertions on outputs and register-file contents.
module tb_mini_alu_gen2;
   logic Clock = 1'b0;
   logic Reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [27:0] rom [256];

   mini_alu_gen2_if #(.ADDR_W(8)) bus ();

   mini_alu_gen2 #(.DATA_W(16), .ADDR_W(8), .RF_DEPTH(256)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   always_comb bus.iInstruction = rom[bus.oInstrAddr];

   function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                       input logic [7:0] s1, input logic [7:0] s0);
      return {op, d, s1, s0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = '0;
   endtask

   task automatic restart();
      Reset = 1'b1;
      @(negedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
   endtask

   initial begin
      clear_rom();
      tick(1);
      check("rst_pc",   32'(bus.oInstrAddr), 32'h0);
      check("rst_led",  32'(bus.oLed),       32'h0);
      check("rst_busy", 32'(bus.oBusy),      32'h0);

      // STO/STO/ADD/LED with back-to-back dependencies
      rom[0] = ins(4'd3, 8'd1, 8'h00, 8'h05);
      rom[1] = ins(4'd3, 8'd2, 8'h00, 8'h07);
      rom[2] = ins(4'd4, 8'd3, 8'd1, 8'd2);
      rom[3] = ins(4'd1, 8'd0, 8'd3, 8'd0);
      restart();
      check("first_fetch_pc", 32'(bus.oInstrAddr), 32'h0);
      tick(4);
      check("led_before", 32'(bus.oLed), 32'h00);
      tick(1);
      check("led_add", 32'(bus.oLed), 32'h0C);
      check("pc_after5", 32'(bus.oInstrAddr), 32'h5);

      // SUB / ADD wrap
      clear_rom();
      rom[0] = ins(4'd3, 8'd1, 8'hFF, 8'hFF);
      rom[1] = ins(4'd3, 8'd2, 8'h00, 8'h02);
      rom[2] = ins(4'd6, 8'd4, 8'd1, 8'd2);
      rom[3] = ins(4'd4, 8'd5, 8'd1, 8'd2);
      rom[4] = ins(4'd1, 8'd0, 8'd4, 8'd0);
      rom[5] = ins(4'd1, 8'd0, 8'd5, 8'd0);
      restart();
      tick(6);
      check("led_sub", 32'(bus.oLed), 32'hFD);
      tick(1);
      check("led_add_wrap", 32'(bus.oLed), 32'h01);
      check("r4_sub", 32'(dut.r_rf[4]), 32'hFFFD);
      check("r5_add", 32'(dut.r_rf[5]), 32'h0001);

      // BLE taken on equal operands, delay slot squashed
      clear_rom();
      rom[0]    = ins(4'd3, 8'd1, 8'h00, 8'h03);
      rom[1]    = ins(4'd3, 8'd2, 8'h00, 8'h03);
      rom[2]    = ins(4'd2, 8'h20, 8'd1, 8'd2);
      rom[3]    = ins(4'd1, 8'd0, 8'd1, 8'd0);
      rom[8'h20] = ins(4'd3, 8'd6, 8'h00, 8'h55);
      rom[8'h21] = ins(4'd1, 8'd0, 8'd6, 8'd0);
      restart();
      tick(4);
      check("ble_taken_pc", 32'(bus.oInstrAddr), 32'h20);
      tick(1);
      check("ble_squash_led", 32'(bus.oLed), 32'h00);
      tick(2);
      check("ble_target_led", 32'(bus.oLed), 32'h55);

      // BLE not taken when R1 > R2
      rom[0] = ins(4'd3, 8'd1, 8'h00, 8'h04);
      restart();
      tick(4);
      check("ble_fall_pc", 32'(bus.oInstrAddr), 32'h4);
      tick(1);
      check("ble_fall_led", 32'(bus.oLed), 32'h04);

      // JMP always taken
      clear_rom();
      rom[0]     = ins(4'd5, 8'h30, 8'd0, 8'd0);
      rom[1]     = ins(4'd3, 8'd7, 8'h00, 8'h11);
      rom[2]     = ins(4'd1, 8'd0, 8'd7, 8'd0);
      rom[8'h30] = ins(4'd3, 8'd7, 8'h00, 8'hA5);
      rom[8'h31] = ins(4'd1, 8'd0, 8'd7, 8'd0);
      restart();
      tick(2);
      check("jmp_pc", 32'(bus.oInstrAddr), 32'h30);
      tick(3);
      check("jmp_led", 32'(bus.oLed), 32'hA5);

      // Opcodes 8-15 behave as NOP
      clear_rom();
      rom[0] = ins(4'd3, 8'd8, 8'h00, 8'h33);
      rom[1] = ins(4'hC, 8'd8, 8'd8, 8'd8);
      rom[2] = ins(4'hF, 8'h40, 8'd8, 8'd8);
      rom[3] = ins(4'd1, 8'd0, 8'd8, 8'd0);
      restart();
      tick(5);
      check("nop_hi_led", 32'(bus.oLed), 32'h33);
      check("nop_hi_pc",  32'(bus.oInstrAddr), 32'h5);

`ifdef MINI_ALU_GEN2_MUL_EN
      // IMUL 0x1234 * 0x0100, then aliased IMUL into R1/R2
      clear_rom();
      rom[0] = ins(4'd3, 8'd1, 8'h12, 8'h34);
      rom[1] = ins(4'd3, 8'd2, 8'h01, 8'h00);
      rom[2] = ins(4'd3, 8'd10, 8'h00, 8'h77);
      rom[3] = ins(4'd3, 8'd11, 8'h00, 8'h66);
      rom[4] = ins(4'd7, 8'd10, 8'd1, 8'd2);
      rom[5] = ins(4'd1, 8'd0, 8'd11, 8'd0);
      rom[6] = ins(4'd1, 8'd0, 8'd10, 8'd0);
      rom[7] = ins(4'd7, 8'd1, 8'd1, 8'd2);
      restart();
      tick(5);
      check("mul_pre_busy", 32'(bus.oBusy), 32'h0);
      check("mul_pre_pc",   32'(bus.oInstrAddr), 32'h5);
      for (int k = 1; k <= 17; k++) begin
         tick(1);
         check($sformatf("mul_busy_%0d", k), 32'(bus.oBusy), (k <= 16) ? 32'h1 : 32'h0);
         check($sformatf("mul_pc_%0d", k), 32'(bus.oInstrAddr), (k <= 16) ? 32'h5 : 32'h6);
      end
      check("mul_r10", 32'(dut.r_rf[10]), 32'h3400);
      check("mul_r11", 32'(dut.r_rf[11]), 32'h0012);
      tick(1);
      check("mul_led_hi", 32'(bus.oLed), 32'h12);
      tick(1);
      check("mul_led_lo", 32'(bus.oLed), 32'h00);
      tick(17);
      check("alias_r1", 32'(dut.r_rf[1]), 32'h3400);
      check("alias_r2", 32'(dut.r_rf[2]), 32'h0012);

      // Reset during the 8th MUL cycle aborts without writing
      clear_rom();
      rom[0] = ins(4'd3, 8'd1, 8'h12, 8'h34);
      rom[1] = ins(4'd3, 8'd2, 8'h01, 8'h00);
      rom[2] = ins(4'd3, 8'd10, 8'h00, 8'h77);
      rom[3] = ins(4'd1, 8'd0, 8'd10, 8'd0);
      rom[4] = ins(4'd7, 8'd10, 8'd1, 8'd2);
      restart();
      tick(13);
      check("abort_busy_before", 32'(bus.oBusy), 32'h1);
      check("abort_led_before",  32'(bus.oLed),  32'h77);
      Reset = 1'b1;
      #1;
      check("abort_busy", 32'(bus.oBusy),      32'h0);
      check("abort_pc",   32'(bus.oInstrAddr), 32'h0);
      check("abort_led",  32'(bus.oLed),       32'h0);
      @(negedge Clock);
      Reset = 1'b0;
      check("abort_r10", 32'(dut.r_rf[10]), 32'h0077);
      tick(1);
      check("abort_restart_pc", 32'(bus.oInstrAddr), 32'h1);
`else
      // Without the multiplier IMUL is a NOP
      clear_rom();
      rom[0] = ins(4'd3, 8'd10, 8'h00, 8'h77);
      rom[1] = ins(4'd3, 8'd11, 8'h00, 8'h66);
      rom[2] = ins(4'd7, 8'd10, 8'd10, 8'd11);
      rom[3] = ins(4'd1, 8'd0, 8'd10, 8'd0);
      rom[4] = ins(4'd1, 8'd0, 8'd11, 8'd0);
      restart();
      tick(3);
      check("nomul_pc_at", 32'(bus.oInstrAddr), 32'h3);
      tick(1);
      check("nomul_pc_next", 32'(bus.oInstrAddr), 32'h4);
      check("nomul_busy",    32'(bus.oBusy),      32'h0);
      tick(1);
      check("nomul_led10", 32'(bus.oLed), 32'h77);
      tick(1);
      check("nomul_led11", 32'(bus.oLed), 32'h66);
      check("nomul_r10", 32'(dut.r_rf[10]), 32'h0077);
      check("nomul_r11", 32'(dut.r_rf[11]), 32'h0066);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mini_alu_gen2.md
MINI_ALU_GEN2 -- requirements
Module: mini_alu_gen2

Interface
REQ-001 Parameter DATA_W, default 16: data path and register width, 8 to 32.
REQ-002 Parameter ADDR_W, default 8: register address, branch target and PC width.
REQ-003 Parameter RF_DEPTH, default 256: register-file word count, at most 2^ADDR_W.
REQ-004 Clock  input  1  single clock; all state changes on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 iInstruction  input  4+3*ADDR_W  instruction at oInstrAddr; bit fields are [op | dst | src1 | src0], with op in the MSBs and src0 in the LSBs.
REQ-007 oInstrAddr  output  ADDR_W  program counter (PC) driving external instruction ROM.
REQ-008 oLed  output  8  LED register.
REQ-009 oBusy  output  1  high while a multicycle multiply is in progress.

Function
REQ-010 Two stages SHALL exist: fetch latches iInstruction into IR at PC, and PC increments modulo 2^ADDR_W; execute decodes IR.
REQ-011 Register-file reads SHALL be combinational, and writes SHALL occur on the edge that ends the execute cycle, so back-to-back dependent instructions need no stall.
REQ-012 Opcodes: 0 NOP, 1 LED, 2 BLE, 3 STO, 4 ADD, 5 JMP, 6 SUB, 7 IMUL; codes 8-15 SHALL execute as NOP.
REQ-013 ADD and SUB SHALL write (R[src1] +/- R[src0]) mod 2^DATA_W to R[dst].
REQ-014 STO SHALL write the immediate {src1,src0} to R[dst], zero-extended or truncated to DATA_W.
REQ-015 LED SHALL load R[src1][7:0] into oLed; no other opcode changes oLed.
REQ-016 JMP SHALL always branch; BLE SHALL branch when R[src1] <= R[src0] (unsigned).
REQ-017 On a taken branch, PC SHALL load dst, the IR SHALL load NOP (one bubble), and execution SHALL resume at dst two cycles after the branch.
REQ-018 IMUL SHALL run an unsigned shift-add multiplier that takes exactly DATA_W cycles in state MUL.
REQ-019 During MUL, oBusy SHALL be 1, PC and IR SHALL hold, and no register write SHALL occur.
REQ-020 On the final MUL cycle, the multiplier SHALL write product[DATA_W-1:0] to R[dst] and product[2*DATA_W-1:DATA_W] to R[(dst+1) mod RF_DEPTH].
REQ-021 After the final MUL cycle, oBusy SHALL fall and fetch SHALL resume; the multiplier sequencer has states IDLE -> MUL (on IMUL) -> IDLE (count=DATA_W-1).
REQ-022 Operands SHALL be captured at MUL entry; if dst aliases a source, the operands captured at entry are used.
REQ-023 Addresses >= RF_DEPTH SHALL read as 0, and writes to them SHALL be dropped.
REQ-024 If IMUL is in execute when an earlier branch has flushed the IR, the NOP bubble SHALL take precedence and no multiply SHALL start.

Reset
REQ-025 Reset SHALL asynchronously clear PC, IR (to NOP), oLed, oBusy, the multiplier state and its counter.
REQ-026 Register-file contents SHALL NOT be reset.
REQ-027 Reset asserted mid-MUL SHALL abort the multiply with no partial write, and after release fetch SHALL restart at address 0.
REQ-028 The first fetch SHALL occur on the first rising edge after Reset deasserts.

Configuration
REQ-029 Macro MINI_ALU_GEN2_MUL_EN: when defined, the multiplier, the MUL state and IMUL are compiled in.
REQ-030 When MINI_ALU_GEN2_MUL_EN is undefined, IMUL SHALL execute as NOP, oBusy SHALL be tied 0, and no multiplier logic SHALL exist.

Verification
REQ-031 Defaults; STO R1=5, STO R2=7, ADD R3=R1+R2, LED R3 -> oLed=0x0C four instructions after reset.
REQ-032 R1=0xFFFF, R2=0x0002, SUB R4=R1-R2 -> R4=0xFFFD; ADD R5=R1+R2 -> R5=0x0001 (wrap).
REQ-033 MUL_EN, R1=0x1234, R2=0x0100, IMUL dst=10 -> oBusy high for 16 cycles, R10=0x3400, R11=0x0012, PC frozen during MUL.
REQ-034 BLE with R1=3, R2=3, dst=0x20 -> taken; the instruction after BLE is not executed, and the next executed is 0x20; with R1=4 and R2=3, the branch falls through.
REQ-035 Reset asserted on the 8th MUL cycle -> oBusy=0, oInstrAddr=0, oLed=0, and R[dst] keeps its old value.
REQ-036 MUL_EN undefined with IMUL dst=10 -> R10 and R11 unchanged, oBusy stays 0, and PC advances by 1.
